// File: rtl/blake2_pkg.sv
// rtl/blake2_pkg.sv - constants shared by the BLAKE2 compression controller
package blake2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_INIT    = 3'd1,
      ST_ISSUE   = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_FINAL   = 3'd4
   } state_e;

   localparam logic [0:7][63:0] IV64 = {
      64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
      64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
   };

   localparam logic [0:7][31:0] IV32 = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   // Row r of SIGMA; entry i is the i-th nibble counted from the most significant end
   localparam logic [0:9][63:0] SIGMA = {
      64'h0123456789ABCDEF, 64'hEA489FD61C02B753, 64'hB8C052FDAE367194, 64'h7931DCBE265A40F8,
      64'h905724AFE1BC683D, 64'h2C6A0B834D75FE19, 64'hC51FED4A0763928B, 64'hDB7EC13950F4862A,
      64'h6FE9B308C2D714A5, 64'hA2847615FB9E3CD0
   };

   // [half][lane] -> v indices {a,b,c,d}, one nibble each; half 0 = columns, 1 = diagonals
   localparam logic [0:1][0:3][15:0] LANE_IDX = {
      16'h048C, 16'h159D, 16'h26AE, 16'h37BF,
      16'h05AF, 16'h16BC, 16'h278D, 16'h349E
   };

   function automatic logic [3:0] sigma_sel(input logic [3:0] row, input logic [3:0] idx);
      logic [63:0] r;
      r = SIGMA[row];
      return r[{4'd15 - idx, 2'b00} +: 4];
   endfunction

endpackage

// File: rtl/blake2_g.sv
// rtl/blake2_g.sv - BLAKE2 G mixing function, two-stage (x half then y half)
module blake2_g #(
   parameter int W  = 32,
   parameter int R1 = 16,
   parameter int R2 = 12,
   parameter int R3 = 8,
   parameter int R4 = 7
) (
   input  logic         clk,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] c_i,
   input  logic [W-1:0] d_i,
   input  logic [W-1:0] x_i,
   input  logic [W-1:0] y_i,
   output logic [W-1:0] a_o,
   output logic [W-1:0] b_o,
   output logic [W-1:0] c_o,
   output logic [W-1:0] d_o
);

   function automatic logic [W-1:0] rotr(input logic [W-1:0] v, input int n);
      return (v >> n) | (v << (W - n));
   endfunction

   logic [W-1:0] a1, b1, c1, d1;
   logic [W-1:0] a1_q, b1_q, c1_q, d1_q;

   // First half of G, mixing in x
   always_comb begin
      a1 = a_i + b_i + x_i;
      d1 = rotr(d_i ^ a1, R1);
      c1 = c_i + d1;
      b1 = rotr(b_i ^ c1, R2);
   end

   // Pipeline register between the x and y halves; y is consumed the following cycle
   always_ff @(posedge clk) begin
      a1_q <= a1;
      b1_q <= b1;
      c1_q <= c1;
      d1_q <= d1;
   end

   // Second half of G, mixing in y
   always_comb begin
      a_o = a1_q + b1_q + y_i;
      d_o = rotr(d1_q ^ a_o, R3);
      c_o = c1_q + d_o;
      b_o = rotr(b1_q ^ c_o, R4);
   end

endmodule

// File: rtl/blake2_msg_sched.sv
// rtl/blake2_msg_sched.sv - maps (round, half) to the eight message word selects
module blake2_msg_sched
   import blake2_pkg::*;
(
   input  logic [3:0]  round_i,
   input  logic        half_i,
   output logic [31:0] sel_o
);

   logic [3:0] row;

   // Select k feeds lane k/2 (x when k even, y when odd); BLAKE2b rounds 10/11 reuse rows 0/1
   always_comb begin
      row   = (round_i >= 4'd10) ? round_i - 4'd10 : round_i;
      sel_o = '0;
      for (int k = 0; k < 8; k++) begin
         sel_o[k*4 +: 4] = sigma_sel(row, {half_i, 3'(k)});
      end
   end

endmodule

// File: rtl/blake2_compress_ctrl.sv
// rtl/blake2_compress_ctrl.sv - sequences one BLAKE2 compression over four G lanes
module blake2_compress_ctrl
   import blake2_pkg::*;
#(
   parameter int W      = 32,
   parameter int ROUNDS = 10,
   parameter int R1     = 16,
   parameter int R2     = 12,
   parameter int R3     = 8,
   parameter int R4     = 7
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   output logic            ready_o,
   input  logic [8*W-1:0]  h_i,
   input  logic [16*W-1:0] m_i,
   input  logic [2*W-1:0]  t_i,
   input  logic            last_i,
   output logic [8*W-1:0]  h_o,
   output logic            valid_o
);

   localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

   state_e             state_q, state_d;
   logic [3:0]         round_q, round_d;
   logic               half_q, half_d;
   logic [7:0][W-1:0]  h_q, h_new, h_o_q;
   logic [15:0][W-1:0] m_q;
   logic [1:0][W-1:0]  t_q;
   logic               f_q;
   logic [W-1:0]       v_q [16];
   logic [W-1:0]       iv [8];
   logic [31:0]        sel;
   logic [3:0]         idx_a [4], idx_b [4], idx_c [4], idx_d [4];
   logic [W-1:0]       g_a [4], g_b [4], g_c [4], g_d [4];

   for (genvar i = 0; i < 8; i++) begin : g_iv
      if (W == 64) begin : g_wide
         assign iv[i] = IV64[i][W-1:0];
      end else begin : g_narrow
         assign iv[i] = IV32[i][W-1:0];
      end
   end

   blake2_msg_sched u_sched (
      .round_i (round_q),
      .half_i  (half_q),
      .sel_o   (sel)
   );

   for (genvar j = 0; j < 4; j++) begin : g_lane
      logic [15:0] lane;
      assign lane     = LANE_IDX[half_q][j];
      assign idx_a[j] = lane[15:12];
      assign idx_b[j] = lane[11:8];
      assign idx_c[j] = lane[7:4];
      assign idx_d[j] = lane[3:0];

      blake2_g #(.W(W), .R1(R1), .R2(R2), .R3(R3), .R4(R4)) u_g (
         .clk (clk),
         .a_i (v_q[idx_a[j]]),
         .b_i (v_q[idx_b[j]]),
         .c_i (v_q[idx_c[j]]),
         .d_i (v_q[idx_d[j]]),
         .x_i (m_q[sel[8*j +: 4]]),
         .y_i (m_q[sel[8*j+4 +: 4]]),
         .a_o (g_a[j]),
         .b_o (g_b[j]),
         .c_o (g_c[j]),
         .d_o (g_d[j])
      );
   end

   // Feed-forward of the final work vector into the chaining value
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         h_new[i] = h_q[i] ^ v_q[i] ^ v_q[i+8];
      end
   end

   // Next-state logic: each half-round is one ISSUE plus one CAPTURE cycle
   always_comb begin
      state_d = state_q;
      round_d = round_q;
      half_d  = half_q;
      case (state_q)
         ST_IDLE:    if (start_i) state_d = ST_INIT;
         ST_INIT: begin
            state_d = ST_ISSUE;
            round_d = '0;
            half_d  = 1'b0;
         end
         ST_ISSUE:   state_d = ST_CAPTURE;
         ST_CAPTURE: begin
            half_d  = ~half_q;
            state_d = ST_ISSUE;
            if (half_q) begin
               if (round_q == LAST_ROUND) begin
                  state_d = ST_FINAL;
                  round_d = '0;
               end else begin
                  round_d = round_q + 4'd1;
               end
            end
         end
         ST_FINAL:   state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Control state and the held result; reset abandons any compression in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         round_q <= '0;
         half_q  <= 1'b0;
         h_o_q   <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         half_q  <= half_d;
         if (state_q == ST_FINAL) h_o_q <= h_new;
      end
   end

   // Datapath: latch the request, build the work vector, write back G results
   always_ff @(posedge clk) begin
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               h_q <= h_i;
               m_q <= m_i;
               t_q <= t_i;
               f_q <= last_i;
            end
         end
         ST_INIT: begin
            for (int i = 0; i < 8; i++) v_q[i] <= h_q[i];
            for (int i = 0; i < 4; i++) v_q[i+8] <= iv[i];
            v_q[12] <= iv[4] ^ t_q[0];
            v_q[13] <= iv[5] ^ t_q[1];
            v_q[14] <= iv[6] ^ {W{f_q}};
            v_q[15] <= iv[7];
         end
         ST_CAPTURE: begin
            for (int j = 0; j < 4; j++) begin
               v_q[idx_a[j]] <= g_a[j];
               v_q[idx_b[j]] <= g_b[j];
               v_q[idx_c[j]] <= g_c[j];
               v_q[idx_d[j]] <= g_d[j];
            end
         end
         default: ;
      endcase
   end

   assign ready_o = (state_q == ST_IDLE);
   assign valid_o = (state_q == ST_FINAL);
   assign h_o     = valid_o ? h_new : h_o_q;

endmodule

// File: tb/tb_blake2_compress_ctrl.sv
// tb/tb_blake2_compress_ctrl.sv - self-checking bench for blake2_compress_ctrl
module tb_blake2_compress_ctrl;

   typedef logic [7:0][63:0]  hv_t;
   typedef logic [15:0][63:0] blk_t;
   typedef struct { logic [255:0] h; int acc; } exp_t;

   localparam logic [63:0] IV [8] = '{
      64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
      64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};

   localparam int SIG [10][16] = '{
      '{ 0, 1, 2, 3, 4, 5, 6, 7, 8, 9,10,11,12,13,14,15},
      '{14,10, 4, 8, 9,15,13, 6, 1,12, 0, 2,11, 7, 5, 3},
      '{11, 8,12, 0, 5, 2,15,13,10,14, 3, 6, 7, 1, 9, 4},
      '{ 7, 9, 3, 1,13,12,11,14, 2, 6, 5,10, 4, 0,15, 8},
      '{ 9, 0, 5, 7, 2, 4,10,15,14, 1,11,12, 6, 8, 3,13},
      '{ 2,12, 6,10, 0,11, 8, 3, 4,13, 7, 5,15,14, 1, 9},
      '{12, 5, 1,15,14,13, 4,10, 0, 7, 6, 3, 9, 2, 8,11},
      '{13,11, 7,14,12, 1, 3, 9, 5, 0,15, 4, 8, 6, 2,10},
      '{ 6,15,14, 9,11, 3, 0, 8,12, 2,13, 7, 1, 4,10, 5},
      '{10, 2, 8, 4, 7, 6, 1, 5,15,11, 9,14, 3,12,13, 0}};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start32 = 1'b0, last32 = 1'b0, ready32, valid32;
   logic [255:0]  h32 = '0, ho32;
   logic [511:0]  m32 = '0;
   logic [63:0]   t32 = '0;
   logic          start64 = 1'b0, last64 = 1'b0, ready64, valid64;
   logic [511:0]  h64 = '0, ho64;
   logic [1023:0] m64 = '0;
   logic [127:0]  t64 = '0;
   int            n_cmp = 0, n_err = 0, cyc = 0;

   blake2_compress_ctrl #(.W(32), .ROUNDS(10), .R1(16), .R2(12), .R3(8), .R4(7)) dut32 (
      .clk(clk), .rst(rst), .start_i(start32), .ready_o(ready32), .h_i(h32), .m_i(m32),
      .t_i(t32), .last_i(last32), .h_o(ho32), .valid_o(valid32));

   blake2_compress_ctrl #(.W(64), .ROUNDS(12), .R1(32), .R2(24), .R3(16), .R4(63)) dut64 (
      .clk(clk), .rst(rst), .start_i(start64), .ready_o(ready64), .h_i(h64), .m_i(m64),
      .t_i(t64), .last_i(last64), .h_o(ho64), .valid_o(valid64));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] req);
      n_cmp++;
      if (obs !== req) begin
         n_err++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, req);
      end
   endtask

   function automatic logic [63:0] wmask(input int w);
      return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
   endfunction

   function automatic logic [63:0] rotr_m(input logic [63:0] x, input int n, input int w);
      return ((x >> n) | (x << (w - n))) & wmask(w);
   endfunction

   // Reference G, applied sequentially on the whole work vector
   function automatic blk_t mix(input blk_t v, input int w, input int a, input int b,
                                input int c, input int d, input logic [63:0] x, input logic [63:0] y);
      logic [63:0] mk;
      int ra, rb, rc, rd;
      mk = wmask(w);
      if (w == 64) begin ra = 32; rb = 24; rc = 16; rd = 63; end
      else begin ra = 16; rb = 12; rc = 8; rd = 7; end
      v[a] = (v[a] + v[b] + (x & mk)) & mk;
      v[d] = rotr_m(v[d] ^ v[a], ra, w);
      v[c] = (v[c] + v[d]) & mk;
      v[b] = rotr_m(v[b] ^ v[c], rb, w);
      v[a] = (v[a] + v[b] + (y & mk)) & mk;
      v[d] = rotr_m(v[d] ^ v[a], rc, w);
      v[c] = (v[c] + v[d]) & mk;
      v[b] = rotr_m(v[b] ^ v[c], rd, w);
      return v;
   endfunction

   // Reference compression F(h, m, t, f)
   function automatic hv_t ref_f(input int w, input int rounds, input hv_t h, input blk_t m,
                                 input logic [63:0] t0, input logic [63:0] t1, input logic f);
      blk_t v;
      hv_t  r;
      int   s;
      for (int i = 0; i < 8; i++) begin
         v[i]   = h[i];
         v[i+8] = (w == 64) ? IV[i] : (IV[i] >> 32);
      end
      v[12] = v[12] ^ (t0 & wmask(w));
      v[13] = v[13] ^ (t1 & wmask(w));
      if (f) v[14] = v[14] ^ wmask(w);
      for (int rd = 0; rd < rounds; rd++) begin
         s = rd % 10;
         v = mix(v, w, 0, 4,  8, 12, m[SIG[s][0]],  m[SIG[s][1]]);
         v = mix(v, w, 1, 5,  9, 13, m[SIG[s][2]],  m[SIG[s][3]]);
         v = mix(v, w, 2, 6, 10, 14, m[SIG[s][4]],  m[SIG[s][5]]);
         v = mix(v, w, 3, 7, 11, 15, m[SIG[s][6]],  m[SIG[s][7]]);
         v = mix(v, w, 0, 5, 10, 15, m[SIG[s][8]],  m[SIG[s][9]]);
         v = mix(v, w, 1, 6, 11, 12, m[SIG[s][10]], m[SIG[s][11]]);
         v = mix(v, w, 2, 7,  8, 13, m[SIG[s][12]], m[SIG[s][13]]);
         v = mix(v, w, 3, 4,  9, 14, m[SIG[s][14]], m[SIG[s][15]]);
      end
      for (int i = 0; i < 8; i++) r[i] = h[i] ^ v[i] ^ v[i+8];
      return r;
   endfunction

   function automatic logic [255:0] flat_h32(input hv_t h);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = h[i][31:0];
      return r;
   endfunction

   function automatic logic [511:0] flat_m32(input blk_t m);
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = m[i][31:0];
      return r;
   endfunction

   // One 32-bit operation observed for 60 cycles, with optional busy pokes and a reset
   task automatic op32(input hv_t hh, input blk_t mm, input logic [63:0] tt, input logic ll,
                       input int poke_a, input int poke_b, input int rst_at,
                       output logic [255:0] got, output int lat, output int pulses,
                       output logic rdy_rst, output logic [255:0] ho_rst, output logic [255:0] ho_late);
      got = '0; lat = -1; pulses = 0; rdy_rst = 1'b0; ho_rst = '1; ho_late = '0;
      @(negedge clk);
      check_eq("op_ready", 512'(ready32), 512'(1));
      h32 = flat_h32(hh); m32 = flat_m32(mm); t32 = tt; last32 = ll; start32 = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         start32 = (k == poke_a) || (k == poke_b);
         if (start32) begin
            for (int i = 0; i < 8; i++)  h32[i*32 +: 32] = $urandom;
            for (int i = 0; i < 16; i++) m32[i*32 +: 32] = $urandom;
            last32 = ~last32;
         end
         rst = (k == rst_at);
         if (valid32) begin
            pulses++;
            if (lat < 0) begin lat = k; got = ho32; end
         end
         if (k == rst_at + 1) begin rdy_rst = ready32; ho_rst = ho32; end
         if (k == 60) ho_late = ho32;
      end
      start32 = 1'b0; rst = 1'b0;
   endtask

   initial begin
      hv_t          abc_h, b_h, rh;
      blk_t         abc_m, b_m, rm;
      logic [255:0] dig_be, abc_dig, abc_ref, got, hr, hl;
      logic [511:0] got64;
      logic [63:0]  rt;
      logic         rl, rr;
      int           lat, pulses, prev_v, n_done, n_issued;
      exp_t         q[$];
      exp_t         e;

      // Reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_ready32", 512'(ready32), 512'(1));
      check_eq("rst_valid32", 512'(valid32), 512'(0));
      check_eq("rst_h32",     512'(ho32),    512'(0));
      check_eq("rst_ready64", 512'(ready64), 512'(1));
      check_eq("rst_valid64", 512'(valid64), 512'(0));
      check_eq("rst_h64",     ho64,          512'(0));
      rst = 1'b0;

      // BLAKE2s "abc"
      for (int i = 0; i < 8; i++) abc_h[i] = IV[i] >> 32;
      abc_h[0] = abc_h[0] ^ 64'h01010020;
      abc_m = '0; abc_m[0] = 64'h00636261;
      dig_be = 256'h508C5E8C327C14E2E1A72BA34EEB452F37458B209ED63A294D999B4C86675982;
      for (int k = 0; k < 32; k++) abc_dig[k*8 +: 8] = dig_be[(31-k)*8 +: 8];
      abc_ref = flat_h32(ref_f(32, 10, abc_h, abc_m, 64'd3, 64'd0, 1'b1));

      op32(abc_h, abc_m, 64'd3, 1'b1, -1, -1, -5, got, lat, pulses, rr, hr, hl);
      check_eq("abc_digest",  512'(got),    512'(abc_dig));
      check_eq("abc_model",   512'(got),    512'(abc_ref));
      check_eq("abc_latency", 512'(lat),    512'(42));
      check_eq("abc_pulses",  512'(pulses), 512'(1));
      check_eq("abc_hold",    512'(hl),     512'(abc_dig));

      // start_i while busy is ignored
      op32(abc_h, abc_m, 64'd3, 1'b1, 5, 20, -5, got, lat, pulses, rr, hr, hl);
      check_eq("busy_digest",  512'(got),    512'(abc_dig));
      check_eq("busy_latency", 512'(lat),    512'(42));
      check_eq("busy_pulses",  512'(pulses), 512'(1));
      check_eq("busy_hold",    512'(hl),     512'(abc_dig));

      // Reset in the middle of an operation
      op32(abc_h, abc_m, 64'd3, 1'b1, -1, -1, 17, got, lat, pulses, rr, hr, hl);
      check_eq("rst_mid_pulses", 512'(pulses), 512'(0));
      check_eq("rst_mid_ready",  512'(rr),     512'(1));
      check_eq("rst_mid_h",      512'(hr),     512'(0));

      // Fresh run after the abort
      op32(abc_h, abc_m, 64'd3, 1'b1, -1, -1, -5, got, lat, pulses, rr, hr, hl);
      check_eq("post_rst_digest",  512'(got), 512'(abc_dig));
      check_eq("post_rst_latency", 512'(lat), 512'(42));

      // BLAKE2b "abc"
      for (int i = 0; i < 8; i++) b_h[i] = IV[i];
      b_h[0] = b_h[0] ^ 64'h01010040;
      b_m = '0; b_m[0] = 64'h0000000000636261;
      @(negedge clk);
      check_eq("b2b_ready64", 512'(ready64), 512'(1));
      h64 = b_h; m64 = b_m; t64 = 128'd3; last64 = 1'b1; start64 = 1'b1;
      lat = -1; got64 = '0;
      for (int k = 1; k <= 70; k++) begin
         @(negedge clk);
         start64 = 1'b0;
         if (valid64 && lat < 0) begin lat = k; got64 = ho64; end
      end
      check_eq("blake2b_latency", 512'(lat), 512'(50));
      check_eq("blake2b_word0",   512'(got64[63:0]), 512'(64'h0D4D1C983FA580BA));
      check_eq("blake2b_model",   got64, ref_f(64, 12, b_h, b_m, 64'd3, 64'd0, 1'b1));

      // Random blocks with start_i held high: back-to-back accepts
      prev_v = -1; n_done = 0; n_issued = 0;
      for (int c = 0; c < 1000 * 43 + 200 && n_done < 1000; c++) begin
         @(negedge clk);
         if (valid32) begin
            if (q.size() == 0) begin
               check_eq("rnd_spurious_valid", 512'(1), 512'(0));
            end else begin
               e = q.pop_front();
               check_eq("rnd_digest",  512'(ho32), 512'(e.h));
               check_eq("rnd_latency", 512'(cyc - e.acc), 512'(42));
            end
            if (prev_v >= 0) check_eq("rnd_period", 512'(cyc - prev_v), 512'(43));
            prev_v = cyc;
            n_done++;
         end
         if (ready32) begin
            if (n_issued < 1000) begin
               for (int i = 0; i < 8; i++)  rh[i] = {32'd0, $urandom};
               for (int i = 0; i < 16; i++) rm[i] = {32'd0, $urandom};
               rt = {$urandom, $urandom};
               rl = 1'($urandom_range(0, 1));
               h32 = flat_h32(rh); m32 = flat_m32(rm); t32 = rt; last32 = rl; start32 = 1'b1;
               e.h   = flat_h32(ref_f(32, 10, rh, rm, {32'd0, rt[31:0]}, {32'd0, rt[63:32]}, rl));
               e.acc = cyc;
               q.push_back(e);
               n_issued++;
            end else begin
               start32 = 1'b0;
            end
         end
      end
      start32 = 1'b0;
      check_eq("rnd_completed", 512'(n_done), 512'(1000));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
